// File: rtl/console_pkg.sv
// ---------------------------------------------------------------------------
// console_pkg
// Shared definitions for the console writer slice: default screen geometry,
// the control codes the writer reacts to, the controller state enumeration
// and two small helpers (cell addressing and printable-range test).
// No ports; imported by console_writer and console_cursor.
// ---------------------------------------------------------------------------
package console_pkg;

   localparam int NUM_ROWS_DEF = 3;
   localparam int NUM_COLS_DEF = 10;

   // Control codes are compared against bits 6:0 only, because the colour
   // bit carries no meaning for control characters.
   localparam logic [6:0] ASCII_BS    = 7'h08;
   localparam logic [6:0] ASCII_LF    = 7'h0A;
   localparam logic [6:0] ASCII_FF    = 7'h0C;
   localparam logic [6:0] ASCII_CR    = 7'h0D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      SCROLL_RD,
      SCROLL_WR,
      CLR_ROW,
      CLR_ALL
   } state_t;

   // Linear cell index of (row, col) in a row-major text buffer.
   function automatic logic [4:0] cellAddr(input logic [1:0] row,
                                           input logic [3:0] col,
                                           input int         numCols);
      return 5'(int'(row) * numCols + int'(col));
   endfunction

   // Printable glyphs occupy 0x20..0x7E; everything else is a control code.
   function automatic logic isPrintable(input logic [6:0] code);
      return (code >= 7'h20) && (code <= 7'h7E);
   endfunction

endpackage

// File: rtl/console_writer_if.sv
// ---------------------------------------------------------------------------
// console_writer_if
// Bundles the character input handshake, the clear request, the text-buffer
// write/read bus and the cursor/busy status of the console writer.
//   in_data/in_valid/in_ready : byte stream in (bit 7 colour, 6:0 ASCII)
//   clear                     : one-cycle blank-and-home request
//   buf_addr/buf_wdata/buf_we : text buffer write port (one cell per cycle)
//   buf_rdata                 : combinational read of cell buf_addr
//   cursor_x/cursor_y/busy    : status
// slave modport is the writer itself, master is whoever drives it.
// ---------------------------------------------------------------------------
interface console_writer_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       clear;
   logic [4:0] buf_addr;
   logic [7:0] buf_wdata;
   logic       buf_we;
   logic [7:0] buf_rdata;
   logic [3:0] cursor_x;
   logic [1:0] cursor_y;
   logic       busy;

   modport master (
      output in_data, in_valid, clear, buf_rdata,
      input  in_ready, buf_addr, buf_wdata, buf_we, cursor_x, cursor_y, busy
   );

   modport slave (
      input  in_data, in_valid, clear, buf_rdata,
      output in_ready, buf_addr, buf_wdata, buf_we, cursor_x, cursor_y, busy
   );

endinterface

// File: rtl/console_writer_cursor.sv
// ---------------------------------------------------------------------------
// console_cursor
// Holds the cursor column/row counters for the console writer.
//   clk, rst_n      : clock, synchronous active-low reset (cursor -> 0,0)
//   home_i          : move to (0,0)
//   carriageRet_i   : column to 0
//   lineFeed_i      : column to 0 and advance one row
//   backspace_i     : step one column left, never wrapping to the row above
//   incr_i          : step one column right, wrapping onto the next row
//   cursorX_o/Y_o   : current position
//   scrollReq_o     : the requested line advance would leave the last row;
//                     the row is held there and the owner must scroll
// ---------------------------------------------------------------------------
module console_cursor
   import console_pkg::*;
#(
   parameter int NUM_ROWS = NUM_ROWS_DEF,
   parameter int NUM_COLS = NUM_COLS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       home_i,
   input  logic       carriageRet_i,
   input  logic       lineFeed_i,
   input  logic       backspace_i,
   input  logic       incr_i,
   output logic [3:0] cursorX_o,
   output logic [1:0] cursorY_o,
   output logic       scrollReq_o
);

   localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);
   localparam logic [1:0] LAST_ROW = 2'(NUM_ROWS - 1);

   logic [3:0] x_q, x_d;
   logic [1:0] y_q, y_d;
   logic       newLine;

   // Next-position logic. A column increment past the last column behaves
   // exactly like a line feed, so both share the newLine path; on the last
   // row the row is pinned and the scroll request tells the owner to move
   // the text up instead.
   always_comb begin
      newLine     = lineFeed_i || (incr_i && (x_q == LAST_COL));
      scrollReq_o = newLine && (y_q == LAST_ROW);
      x_d         = x_q;
      y_d         = y_q;
      if (home_i) begin
         x_d = 4'd0;
         y_d = 2'd0;
      end else if (carriageRet_i) begin
         x_d = 4'd0;
      end else if (newLine) begin
         x_d = 4'd0;
         if (y_q != LAST_ROW) begin
            y_d = y_q + 2'd1;
         end
      end else if (backspace_i) begin
         if (x_q != 4'd0) begin
            x_d = x_q - 4'd1;
         end
      end else if (incr_i) begin
         x_d = x_q + 4'd1;
      end
   end

   // Position registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q <= 4'd0;
         y_q <= 2'd0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign cursorX_o = x_q;
   assign cursorY_o = y_q;

endmodule

// File: rtl/console_writer.sv
// ---------------------------------------------------------------------------
// console_writer
// Turns a stream of character bytes into writes on a NUM_ROWS x NUM_COLS
// text buffer: prints glyphs at the cursor, handles BS/LF/CR/FF, scrolls the
// screen up by one row when the cursor runs off the bottom, and blanks the
// whole screen on clear.
//   clk   : clock, everything on the rising edge
//   rst_n : synchronous active-low reset (buffer contents are not touched)
//   bus   : console_writer_if.slave (input stream, buffer port, status)
// ---------------------------------------------------------------------------
module console_writer
   import console_pkg::*;
#(
   parameter int NUM_ROWS = NUM_ROWS_DEF,
   parameter int NUM_COLS = NUM_COLS_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   console_writer_if.slave        bus
);

   localparam logic [4:0] ROW_STRIDE     = 5'(NUM_COLS);
   localparam logic [4:0] LAST_COPY      = 5'((NUM_ROWS - 1) * NUM_COLS - 1);
   localparam logic [4:0] LAST_ROW_START = 5'((NUM_ROWS - 1) * NUM_COLS);
   localparam logic [4:0] LAST_CELL      = 5'(NUM_ROWS * NUM_COLS - 1);

   state_t     state_q;
   logic [4:0] bufAddr_q;
   logic [7:0] bufWdata_q;
   logic       bufWe_q;
   logic       advance_q;

   logic [6:0] code;
   logic       accept;
   logic       curHome;
   logic       curCr;
   logic       curLf;
   logic       curBs;
   logic       curInc;
   logic       scrollReq;
   logic [3:0] curX;
   logic [1:0] curY;

   // Input decode. A pending clear masks the handshake so that no byte is
   // swallowed in the cycle the screen is being reset.
   assign code         = bus.in_data[6:0];
   assign bus.in_ready = (state_q == IDLE) && !bus.clear;
   assign accept       = bus.in_valid && bus.in_ready;

   // Cursor commands. The column advance happens only when a glyph write
   // completes (a backspace blank-out must not move the cursor forward), and
   // homing waits for the last blanked cell so a restarted clear re-homes.
   assign curCr   = accept && (code == ASCII_CR);
   assign curLf   = accept && (code == ASCII_LF);
   assign curBs   = accept && (code == ASCII_BS) && (curX != 4'd0);
   assign curInc  = (state_q == WRITE) && advance_q && !bus.clear;
   assign curHome = (state_q == CLR_ALL) && !bus.clear && (bufAddr_q == LAST_CELL);

   console_cursor #(
      .NUM_ROWS (NUM_ROWS),
      .NUM_COLS (NUM_COLS)
   ) cursorUnit (
      .clk           (clk),
      .rst_n         (rst_n),
      .home_i        (curHome),
      .carriageRet_i (curCr),
      .lineFeed_i    (curLf),
      .backspace_i   (curBs),
      .incr_i        (curInc),
      .cursorX_o     (curX),
      .cursorY_o     (curY),
      .scrollReq_o   (scrollReq)
   );

   // Controller. Buffer address, data and strobe are registered and always
   // loaded together with the state they belong to, so each state sees its
   // own cell on the bus for its whole cycle. In a scroll the address
   // alternates between source (i+NUM_COLS) and destination (i); the data
   // register doubles as the latch for the byte read in SCROLL_RD. Clear
   // overrides everything and restarts the blanking at cell 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bufAddr_q  <= 5'd0;
         bufWdata_q <= 8'd0;
         bufWe_q    <= 1'b0;
         advance_q  <= 1'b0;
      end else if (bus.clear) begin
         state_q    <= CLR_ALL;
         bufAddr_q  <= 5'd0;
         bufWdata_q <= ASCII_SPACE;
         bufWe_q    <= 1'b1;
         advance_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (isPrintable(code)) begin
                     state_q    <= WRITE;
                     bufAddr_q  <= cellAddr(curY, curX, NUM_COLS);
                     bufWdata_q <= bus.in_data;
                     bufWe_q    <= 1'b1;
                     advance_q  <= 1'b1;
                  end else if (curBs) begin
                     state_q    <= WRITE;
                     bufAddr_q  <= cellAddr(curY, curX - 4'd1, NUM_COLS);
                     bufWdata_q <= ASCII_SPACE;
                     bufWe_q    <= 1'b1;
                     advance_q  <= 1'b0;
                  end else if (code == ASCII_FF) begin
                     state_q    <= CLR_ALL;
                     bufAddr_q  <= 5'd0;
                     bufWdata_q <= ASCII_SPACE;
                     bufWe_q    <= 1'b1;
                  end else if (scrollReq) begin
                     state_q   <= SCROLL_RD;
                     bufAddr_q <= ROW_STRIDE;
                     bufWe_q   <= 1'b0;
                  end
               end
            end
            WRITE: begin
               bufWe_q <= 1'b0;
               if (scrollReq) begin
                  state_q   <= SCROLL_RD;
                  bufAddr_q <= ROW_STRIDE;
               end else begin
                  state_q <= IDLE;
               end
            end
            SCROLL_RD: begin
               state_q    <= SCROLL_WR;
               bufAddr_q  <= bufAddr_q - ROW_STRIDE;
               bufWdata_q <= bus.buf_rdata;
               bufWe_q    <= 1'b1;
            end
            SCROLL_WR: begin
               if (bufAddr_q == LAST_COPY) begin
                  state_q    <= CLR_ROW;
                  bufAddr_q  <= LAST_ROW_START;
                  bufWdata_q <= ASCII_SPACE;
                  bufWe_q    <= 1'b1;
               end else begin
                  state_q   <= SCROLL_RD;
                  bufAddr_q <= bufAddr_q + ROW_STRIDE + 5'd1;
                  bufWe_q   <= 1'b0;
               end
            end
            CLR_ROW, CLR_ALL: begin
               if (bufAddr_q == LAST_CELL) begin
                  state_q <= IDLE;
                  bufWe_q <= 1'b0;
               end else begin
                  bufAddr_q <= bufAddr_q + 5'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               bufWe_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.buf_addr  = bufAddr_q;
   assign bus.buf_wdata = bufWdata_q;
   assign bus.buf_we    = bufWe_q;
   assign bus.cursor_x  = curX;
   assign bus.cursor_y  = curY;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 3, meaning text rows in the console buffer.
REQ-002 SHALL have parameter NUM_COLS, default 10, meaning characters per row.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port in_data  input  8  bit 7 = colour select, bits 6:0 = ASCII code.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port clear  input  1  single-cycle request to blank the screen and home the cursor.
REQ-009 SHALL have port buf_addr  output  5  text buffer cell index, row*NUM_COLS+col.
REQ-010 SHALL have port buf_wdata  output  8  byte written to the text buffer.
REQ-011 SHALL have port buf_we  output  1  write strobe; one cell per cycle.
REQ-012 SHALL have port buf_rdata  input  8  combinational read of cell buf_addr, same cycle.
REQ-013 SHALL have port cursor_x  output  4  current column, 0..NUM_COLS-1.
REQ-014 SHALL have port cursor_y  output  2  current row, 0..NUM_ROWS-1.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, WRITE, SCROLL_RD, SCROLL_WR, CLR_ROW and CLR_ALL.
REQ-017 SHALL drive in_ready = (state==IDLE) & ~clear; a byte is accepted when in_valid & in_ready.
REQ-018 SHALL, for an accepted printable byte (bits 6:0 in 0x20..0x7E), enter WRITE and, in the next cycle, assert buf_we with buf_addr = cursor cell and buf_wdata = in_data (colour bit kept).
REQ-019 SHALL, at the end of WRITE, increment cursor_x; at NUM_COLS it wraps to 0 and cursor_y increments.
REQ-020 SHALL, when cursor_y would reach NUM_ROWS, hold cursor_y at NUM_ROWS-1, set cursor_x to 0 and enter SCROLL_RD.
REQ-021 SHALL treat LF (0x0A) as CR+LF: cursor_x=0, then cursor_y++ or scroll per REQ-020, with no buffer write.
REQ-022 SHALL treat CR (0x0D) as cursor_x=0, no write.
REQ-023 SHALL treat BS (0x08) with cursor_x>0 as cursor_x-- followed by a WRITE of 0x20 at the new cell; BS at cursor_x=0 is consumed as a no-op (no row wrap).
REQ-024 SHALL treat FF (0x0C) as equivalent to clear.
REQ-025 SHALL consume all other control codes (0x00..0x1F, 0x7F) with no effect; bit 7 is ignored for control codes.
REQ-026 SHALL, in a scroll, for i = 0..(NUM_ROWS-1)*NUM_COLS-1, set buf_addr=i+NUM_COLS in SCROLL_RD and latch buf_rdata, then write the latched byte to buf_addr=i in SCROLL_WR; 2 cycles per cell.
REQ-027 SHALL, after the last copy, run CLR_ROW, writing 0x20 to each cell of the last row in ascending order (1 cell/cycle), then return to IDLE; a scroll with defaults is 50 cycles.
REQ-028 SHALL, in CLR_ALL, write 0x20 to cells 0..NUM_ROWS*NUM_COLS-1 ascending (30 cycles with defaults), set cursor to (0,0), then go to IDLE.
REQ-029 SHALL give clear priority in every state: an in-progress scroll, write or clear is aborted and CLR_ALL restarts from cell 0 in the following cycle.
REQ-030 SHALL keep buf_we low in IDLE and in SCROLL_RD, and hold buf_addr below NUM_ROWS*NUM_COLS at all times.
REQ-031 SHALL keep cursor_x and cursor_y unchanged during SCROLL_*/CLR_ROW.

Reset
REQ-032 SHALL, on rst_n low at a clock edge, set state=IDLE, cursor=(0,0), buf_we=0, busy=0 and latched data=0, aborting any operation immediately.
REQ-033 SHALL not clear the text buffer on reset; software issues clear when it needs a blank screen.

Structure
REQ-034 SHALL place NUM_ROWS/NUM_COLS defaults, control-code constants (BS, LF, FF, CR, SPACE) and the state enumeration in package console_pkg.
REQ-035 SHALL use one sub-module, console_cursor, holding the x/y counters with increment, wrap, backspace and home operations and a scroll-request output.

Verification
REQ-036 SHALL cover: reset, then 'A' (0x41) -> one buf_we at addr 0 with data 0x41 one cycle after acceptance; cursor=(1,0).
REQ-037 SHALL cover: 30 printable bytes from a cleared screen -> last write at addr 29, then 50 busy cycles; cells 0..19 hold the old rows 1..2, cells 20..29 hold 0x20, cursor=(0,2).
REQ-038 SHALL cover: 0xC2 ('B' with colour bit set), then BS -> addr 0 is written with 0xC2, then with 0x20; cursor=(0,0); a second BS leaves the cursor at (0,0) with no write.
REQ-039 SHALL cover: cursor at (4,1), then LF -> cursor=(0,2) with no buf_we; CR at (7,2) -> cursor=(0,2).
REQ-040 SHALL cover: clear pulsed at scroll cycle 10 -> CLR_ALL writes 0x20 to addr 0..29 starting the next cycle; cursor=(0,0); in_ready stays low until IDLE.
REQ-041 SHALL cover: rst_n low mid-CLR_ALL -> buf_we=0 and busy=0 on the next edge; buffer contents untouched.
